// File: rtl/perf_stat_if.sv
// Bus bundle between the pipeline and perf_stat_unit: event/syscall/run-control requests in,
// run-state flags and registered read data out.
interface perf_stat_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned N_EVT = 4,
    parameter int unsigned SEL_W = 3
) ();
    logic [N_EVT-1:0] evt;
    logic             halt_req;
    logic             pause_req;
    logic             resume;
    logic             sys_we;
    logic [CNT_W-1:0] sys_data;
    logic             snap;
    logic             rd_shadow;
    logic [SEL_W-1:0] rd_sel;
    logic             go;
    logic             halted;
    logic             paused;
    logic [CNT_W-1:0] rd_data;

    modport master (
        output evt, halt_req, pause_req, resume, sys_we, sys_data, snap, rd_shadow, rd_sel,
        input  go, halted, paused, rd_data
    );

    modport slave (
        input  evt, halt_req, pause_req, resume, sys_we, sys_data, snap, rd_shadow, rd_sel,
        output go, halted, paused, rd_data
    );
endinterface

// File: rtl/perf_stat_unit.sv
// Run-control FSM (RUN/PAUSED/HALTED), cycle/event counters, syscall register, shadow bank and
// registered read port. Define PERF_CNT_SAT_EN to make counters saturate instead of wrapping.
module perf_stat_unit #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned N_EVT = 4,
    parameter int unsigned SEL_W = 3
) (
    input logic        clk,
    input logic        rst,
    perf_stat_if.slave bus
);
    localparam int unsigned NReg = N_EVT + 2;

    typedef enum logic [1:0] {StRun, StPaused, StHalted} state_e;

    state_e state_q, state_d;

    // Entry 0 is the cycle counter, 1..N_EVT the event counters, NReg-1 the syscall register.
    logic [NReg-1:0][CNT_W-1:0] live_q, live_d;
    logic [NReg-1:0][CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0]           rd_data_q, rd_data_d;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PERF_CNT_SAT_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StHalted;
                end else if (bus.pause_req) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (bus.halt_req) begin
                    state_d = StHalted;
                end else if (bus.resume) begin
                    state_d = StRun;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        live_d = live_q;
        if (state_q == StRun) begin
            live_d[0] = cnt_inc(live_q[0]);
            for (int i = 0; i < N_EVT; i++) begin
                if (bus.evt[i]) begin
                    live_d[i+1] = cnt_inc(live_q[i+1]);
                end
            end
            if (bus.sys_we) begin
                live_d[NReg-1] = bus.sys_data;
            end
        end
    end

    // Snapshot takes the pre-edge live values, so this edge's increment is excluded.
    always_comb begin
        shd_d = bus.snap ? live_q : shd_q;
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NReg; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_data_d = bus.rd_shadow ? shd_q[i] : live_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            live_q    <= '0;
            shd_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            shd_q     <= shd_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.go      = (state_q == StRun);
    assign bus.halted  = (state_q == StHalted);
    assign bus.paused  = (state_q == StPaused);
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_perf_stat_unit.sv
// Randomized plus directed bench for perf_stat_unit against a counting reference model; a second
// 4-bit instance exercises overflow (wrap, or saturate under PERF_CNT_SAT_EN).
module tb_perf_stat_unit;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned N_EVT = 4;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned NReg  = N_EVT + 2;
    localparam longint unsigned MASK  = (64'd1 << CNT_W) - 1;
    localparam longint unsigned SMASK = 64'd15;
    localparam int MRun = 0, MPaused = 1, MHalted = 2;
`ifdef PERF_CNT_SAT_EN
    localparam longint unsigned SAT_EXP = 15;
`else
    localparam longint unsigned SAT_EXP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    perf_stat_if #(.CNT_W(CNT_W), .N_EVT(N_EVT), .SEL_W(SEL_W)) bus ();
    perf_stat_if #(.CNT_W(4), .N_EVT(N_EVT), .SEL_W(SEL_W)) sbus ();

    perf_stat_unit #(.CNT_W(CNT_W), .N_EVT(N_EVT), .SEL_W(SEL_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    perf_stat_unit #(.CNT_W(4), .N_EVT(N_EVT), .SEL_W(SEL_W)) dut_small (
        .clk(clk),
        .rst(rst),
        .bus(sbus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int              m_state = MRun;
    longint unsigned m_reg[NReg];
    longint unsigned m_shd[NReg];
    longint unsigned m_rd  = 0;
    longint unsigned s_cnt = 0;
    longint unsigned s_rd  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned inc(input longint unsigned v, input longint unsigned m);
`ifdef PERF_CNT_SAT_EN
        return (v == m) ? v : v + 1;
`else
        return (v + 1) & m;
`endif
    endfunction

    // One clock: update the model from the inputs sampled at the edge, then compare at negedge.
    task automatic step();
        longint unsigned nrd;
        int sel;
        @(posedge clk);
        sel = int'(bus.rd_sel);
        if (rst) begin
            for (int i = 0; i < NReg; i++) begin
                m_reg[i] = 0;
                m_shd[i] = 0;
            end
            m_rd = 0;
            m_state = MRun;
            s_cnt = 0;
            s_rd = 0;
        end else begin
            nrd = 0;
            if (sel < NReg) nrd = bus.rd_shadow ? m_shd[sel] : m_reg[sel];
            if (bus.snap) m_shd = m_reg;
            if (m_state == MRun) begin
                m_reg[0] = inc(m_reg[0], MASK);
                for (int i = 0; i < N_EVT; i++) begin
                    if (bus.evt[i]) m_reg[i+1] = inc(m_reg[i+1], MASK);
                end
                if (bus.sys_we) m_reg[NReg-1] = bus.sys_data;
            end
            m_rd = nrd;
            if (m_state == MRun) begin
                if (bus.halt_req) m_state = MHalted;
                else if (bus.pause_req) m_state = MPaused;
            end else if (m_state == MPaused) begin
                if (bus.halt_req) m_state = MHalted;
                else if (bus.resume) m_state = MRun;
            end
            // Small instance: always running, all events high, so every counter equals s_cnt.
            s_rd = (int'(sbus.rd_sel) <= N_EVT) ? s_cnt : 0;
            s_cnt = inc(s_cnt, SMASK);
        end
        @(negedge clk);
        check("go", bus.go, m_state == MRun);
        check("halted", bus.halted, m_state == MHalted);
        check("paused", bus.paused, m_state == MPaused);
        check("rd_data", bus.rd_data, m_rd);
        check("small_rd_data", sbus.rd_data, s_rd);
    endtask

    task automatic idle();
        bus.evt       = '0;
        bus.halt_req  = 1'b0;
        bus.pause_req = 1'b0;
        bus.resume    = 1'b0;
        bus.sys_we    = 1'b0;
        bus.sys_data  = '0;
        bus.snap      = 1'b0;
        bus.rd_shadow = 1'b0;
        bus.rd_sel    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int go_low;
        idle();
        sbus.evt       = '1;
        sbus.halt_req  = 1'b0;
        sbus.pause_req = 1'b0;
        sbus.resume    = 1'b0;
        sbus.sys_we    = 1'b0;
        sbus.sys_data  = '0;
        sbus.snap      = 1'b0;
        sbus.rd_shadow = 1'b0;
        sbus.rd_sel    = '0;

        // Reset values and 4-bit overflow after 17 counting cycles.
        do_reset();
        check("rst_go", bus.go, 1);
        check("rst_halted", bus.halted, 0);
        check("rst_paused", bus.paused, 0);
        check("rst_rd", bus.rd_data, 0);
        for (int i = 0; i < 18; i++) step();
        check("small_overflow", sbus.rd_data, SAT_EXP);
        sbus.rd_sel = 3'd7;
        step();
        check("small_out_of_range", sbus.rd_data, 0);

        // 10 cycles with evt[0], then live reads of cycle and event 0.
        do_reset();
        bus.evt = 4'b0001;
        for (int i = 0; i < 10; i++) step();
        bus.evt = '0;
        bus.rd_sel = 3'd0;
        step();
        check("d1_cycle", bus.rd_data, 10);
        bus.rd_sel = 3'd1;
        step();
        check("d1_evt0", bus.rd_data, 10);

        // Pause at cycle 6 with events flooding while paused.
        do_reset();
        for (int i = 0; i < 5; i++) step();
        bus.pause_req = 1'b1;
        step();
        bus.pause_req = 1'b0;
        go_low = bus.go ? 0 : 1;
        bus.evt = '1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (!bus.go) go_low++;
        end
        bus.evt = '0;
        bus.resume = 1'b1;
        step();
        if (!bus.go) go_low++;
        bus.resume = 1'b0;
        check("pause_go_low_cycles", go_low, 8);
        bus.rd_sel = 3'd0;
        step();
        check("pause_cycle", bus.rd_data, 6);
        bus.rd_sel = 3'd4;
        step();
        check("pause_evt3", bus.rd_data, 0);

        // Simultaneous halt and pause; halt is sticky until rst.
        do_reset();
        bus.halt_req = 1'b1;
        bus.pause_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        bus.pause_req = 1'b0;
        check("both_halted", bus.halted, 1);
        check("both_paused", bus.paused, 0);
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        check("halt_resume_go", bus.go, 0);
        do_reset();
        check("halt_rst_go", bus.go, 1);
        step();
        check("halt_rst_cycle", bus.rd_data, 0);

        // Syscall register ignores writes outside RUN.
        do_reset();
        bus.sys_we = 1'b1;
        bus.sys_data = 32'h1234;
        step();
        bus.sys_we = 1'b0;
        bus.pause_req = 1'b1;
        step();
        bus.pause_req = 1'b0;
        bus.sys_we = 1'b1;
        bus.sys_data = 32'hFFFF;
        step();
        bus.sys_we = 1'b0;
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        bus.rd_sel = 3'(N_EVT + 1);
        step();
        check("sys_hold", bus.rd_data, 32'h1234);

        // Snapshot at 20, live vs shadow reads, snap with same-edge shadow read.
        do_reset();
        for (int i = 0; i < 20; i++) step();
        bus.snap = 1'b1;
        step();
        bus.snap = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.rd_sel = 3'd0;
        step();
        check("snap_live", bus.rd_data, 25);
        bus.rd_shadow = 1'b1;
        step();
        check("snap_shadow", bus.rd_data, 20);
        bus.snap = 1'b1;
        step();
        bus.snap = 1'b0;
        check("snap_same_edge_old", bus.rd_data, 20);
        step();
        check("snap_same_edge_new", bus.rd_data, 27);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.evt       = N_EVT'($urandom());
            bus.halt_req  = ($urandom_range(0, 199) == 0);
            bus.pause_req = ($urandom_range(0, 19) == 0);
            bus.resume    = ($urandom_range(0, 7) == 0);
            bus.sys_we    = ($urandom_range(0, 3) == 0);
            bus.sys_data  = $urandom();
            bus.snap      = ($urandom_range(0, 9) == 0);
            bus.rd_shadow = $urandom_range(0, 1) == 1;
            bus.rd_sel    = SEL_W'($urandom_range(0, 7));
            sbus.rd_sel   = SEL_W'($urandom_range(0, 7));
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/perf_stat_unit.md
# perf_stat_unit

Parametrised run-control and performance-statistics unit for the five-stage pipeline CPU. Generalises the single-purpose statistics counters to N_EVT event channels of configurable width. Adds a RUN/PAUSED/HALTED run-control FSM driven by decoded syscalls, a snapshot shadow bank and a registered read port for the seven-segment display path. It sits beside the EXE stage. It takes event pulses from EXE, takes halt/pause requests from WB, and drives the pipeline-wide `go` freeze signal.

## Interface
- CNT_W, 32, width of every counter and of the syscall output register
- N_EVT, 4, number of event counters (e.g. unconditional jumps, conditional branches, taken branches, bubbles)
- SEL_W, 3, read-select width; must satisfy 2^SEL_W >= N_EVT+2

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- evt  in  N_EVT  per-channel event pulse, one count per cycle when high
- halt_req  in  1  syscall exit ($v0==10) reached WB
- pause_req  in  1  syscall pause ($v0==0x32) reached WB
- resume  in  1  single-cycle resume pulse (debounced button)
- sys_we  in  1  syscall print ($v0==34) in EXE
- sys_data  in  CNT_W  value to latch into syscall output register ($a0)
- snap  in  1  copy live counters into shadow bank
- rd_shadow  in  1  1: read shadow bank, 0: read live counters
- rd_sel  in  SEL_W  index: 0 cycle counter, 1..N_EVT event counters, N_EVT+1 syscall register
- go  out  1  1 when state is RUN; pipeline registers and PC advance only when high
- halted  out  1  state is HALTED
- paused  out  1  state is PAUSED
- rd_data  out  CNT_W  registered read data

## Operation
- FSM states: RUN, PAUSED, HALTED. Reset state is RUN.
- FSM transition priority, evaluated each edge:
  - RUN: halt_req -> HALTED; else pause_req -> PAUSED.
  - PAUSED: halt_req -> HALTED; else resume -> RUN.
  - HALTED: sticky until rst; resume and pause_req ignored.
- halt_req and pause_req asserted together: go to HALTED.
- Cycle counter: increments on every edge where the registered state is RUN.
- Event counter i: increments when evt[i] is high and the registered state is RUN. Events arriving in PAUSED or HALTED are dropped.
- The cycle on which halt_req/pause_req is sampled is still a RUN cycle. Its cycle and events are counted.
- Syscall register: loads sys_data when sys_we is high and the state is RUN. Otherwise it holds.
- Shadow bank: on snap, every shadow entry (cycle, events, syscall) takes the current live register value, i.e. excluding this edge's increment. snap is honoured in all states.
- Read mux: rd_sel out of range (> N_EVT+1) returns 0.
- Counter arithmetic is unsigned CNT_W. Overflow behaviour is set by the macro in Configuration.

## Timing
- Reset values: all counters, shadow entries and the syscall register 0; rd_data 0; state RUN; go=1, halted=0, paused=0.
- go/halted/paused are decoded from the registered state, with no combinational path from halt_req. go falls the cycle after halt_req is sampled.
- rd_data has 1-cycle latency: it reflects rd_sel/rd_shadow and the register values present before the same edge.
- snap and a shadow read on the same edge: rd_data returns the old shadow value. The new value is visible one cycle later.
- rst mid-PAUSED or mid-HALTED returns to RUN with all counts 0 on the next edge.
- resume in RUN has no effect.

## Configuration
- PERF_CNT_SAT_EN defined: counters saturate at 2^CNT_W-1 and hold. This applies to the cycle and event counters only; the syscall register is unaffected.
- PERF_CNT_SAT_EN undefined: counters wrap modulo 2^CNT_W (all-ones + 1 -> 0).

## Test plan
- Reset, then 10 RUN cycles with evt=4'b0001 every cycle, then read rd_sel=0 and rd_sel=1 live -> rd_data=10 and 10 respectively, one cycle after each select.
- pause_req pulse at cycle 5, then 7 idle cycles with evt=4'b1111, then resume -> go=0 for exactly 8 cycles. Cycle counter = 6 at resume (pause cycle counted). Event counters show no increments during PAUSED.
- halt_req and pause_req in the same cycle -> halted=1, paused=0. A later resume leaves go=0. rst returns go=1 and all counters 0.
- sys_we with sys_data=32'h1234 in RUN, then sys_we with 32'hFFFF while PAUSED -> rd_sel=N_EVT+1 reads 32'h1234.
- Snapshot at cycle count 20, then run 5 more cycles -> shadow read of rd_sel=0 gives 20 and live read gives 25. With snap and a shadow read on the same edge, rd_data returns the previous shadow value.
- CNT_W=4, 17 RUN cycles -> cycle counter = 15 with PERF_CNT_SAT_EN defined, 1 without. rd_sel=7 with N_EVT=4 -> rd_data=0.
